// File: rtl/trans_if.sv
// trans_if: byte-in / word-out bundle of the transaction source.
//
// Handshakes:
//   Byte side: a byte moves on a rising clk edge where byte_valid_i and
//   byte_ready_o are both 1. The driver may raise byte_valid_i at any time
//   and hold it while byte_ready_o is low; nothing is taken in that case.
//   Word side: valid_o rises with a new data_o and both stay unchanged until
//   an edge where ack_i is 1. That edge retires the word. ack_i is a
//   one-cycle pulse. An ack_i seen while valid_o is low has no effect.
//
// Signals:
//   byte_i[7:0]     stream byte; the first byte of a word lands in bits [127:120]
//   byte_valid_i    byte_i is valid
//   byte_ready_o    source can take a byte this cycle
//   block_start_i   pulse: mark the next completed word as a block start
//   data_o[127:0]   transaction word being presented
//   valid_o         data_o is valid; held until ack_i
//   ack_i           consumer has taken the presented word
//
// Modports: master is the transaction source; slave is the side that
// feeds bytes and acknowledges words.
interface trans_if;
  logic [7:0]   byte_i;
  logic         byte_valid_i;
  logic         byte_ready_o;
  logic         block_start_i;
  logic [127:0] data_o;
  logic         valid_o;
  logic         ack_i;

  modport master (
    input  byte_i, byte_valid_i, block_start_i, ack_i,
    output byte_ready_o, data_o, valid_o
  );

  modport slave (
    output byte_i, byte_valid_i, block_start_i, ack_i,
    input  byte_ready_o, data_o, valid_o
  );
endinterface

// File: rtl/trans_source.sv
// trans_source: initiator side of the 128-bit transaction valid/ack link.
//
// Assembles a byte stream into 128-bit words, queues them in a DEPTH-entry
// word FIFO and presents the FIFO head on data_o/valid_o until it is acked.
// A partial word is discarded when bytes stop arriving for IDLE_TIMEOUT
// cycles. A word left unacked for ACK_TIMEOUT cycles raises a sticky error,
// but the word keeps being presented.
//
// Word layout: [127:80] sender id, [79:32] receiver id, [31:10] amount,
// [9] block start, [8:0] passthrough.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   bus            trans_if.master (byte input, word output, ack)
//   sent_count_o   words acked since reset (wraps)
//   drop_count_o   partial words discarded by idle timeout (saturates)
//   ack_err_o      sticky ack-timeout flag, cleared only by rst
//   busy_o         partial word in progress, FIFO non-empty, or valid_o high
//   state_dbg_o    output FSM state: 0 = IDLE, 1 = PRESENT
module trans_source #(
  parameter int DEPTH        = 4,
  parameter int IDLE_TIMEOUT = 1024,
  parameter int ACK_TIMEOUT  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  trans_if.master     bus,
  output logic [31:0] sent_count_o,
  output logic [15:0] drop_count_o,
  output logic        ack_err_o,
  output logic        busy_o,
  output logic        state_dbg_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam int KW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);
  localparam logic [KW-1:0] ACK_LAST   = KW'(ACK_TIMEOUT - 1);
  localparam logic [KW-1:0] ACK_MAX    = KW'(ACK_TIMEOUT);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [3:0]    byte_idx_q;
  logic [127:0]  partial_q;
  logic          blk_pend_q;
  logic [IW-1:0] idle_cnt_q;

  logic [127:0]  fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  state_t        state_q;
  state_t        state_d;
  logic [127:0]  data_q;
  logic          valid_q;
  logic [KW-1:0] ack_cnt_q;
  logic [31:0]   sent_q;
  logic [15:0]   drop_q;
  logic          ack_err_q;

  // ---------------------------------------------------------------------
  // Byte side
  // ---------------------------------------------------------------------
  logic         byte_ready;
  logic         accept;
  logic         push;
  logic         idle_expire;
  logic [127:0] full_word;

  // The word FIFO entry under presentation is still counted, so a full
  // FIFO includes the word on data_o.
  assign byte_ready = (count_q != FULL_COUNT);
  assign accept     = bus.byte_valid_i && byte_ready;
  assign push       = accept && (byte_idx_q == 4'd15);

  // The timer counts idle edges since the last accepted byte; the edge on
  // which it would reach IDLE_TIMEOUT discards the partial word. A byte
  // arriving on that same edge wins and keeps the word alive.
  assign idle_expire = (byte_idx_q != 4'd0) && !accept && (idle_cnt_q == IDLE_LAST);

  // Bytes are shifted in from the bottom, so after 16 accepts byte k sits
  // at [127-8k -: 8]. A block-start pulse on the completing cycle counts.
  always_comb begin
    full_word    = {partial_q[119:0], bus.byte_i};
    full_word[9] = full_word[9] | blk_pend_q | bus.block_start_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx_q <= '0;
      partial_q  <= '0;
      blk_pend_q <= 1'b0;
      idle_cnt_q <= '0;
      drop_q     <= '0;
    end else begin
      if (accept) begin
        // byte_idx_q wraps from 15 back to 0 on the completing byte.
        byte_idx_q <= byte_idx_q + 4'd1;
        partial_q  <= push ? '0 : {partial_q[119:0], bus.byte_i};
        idle_cnt_q <= '0;
      end else if (idle_expire) begin
        byte_idx_q <= '0;
        partial_q  <= '0;
        idle_cnt_q <= '0;
        if (drop_q != 16'hFFFF) begin
          drop_q <= drop_q + 16'd1;
        end
      end else if (byte_idx_q != 4'd0) begin
        idle_cnt_q <= idle_cnt_q + IW'(1);
      end else begin
        idle_cnt_q <= '0;
      end

      // The pending flag is consumed only by a completed word; a discard
      // leaves it armed for the next word.
      if (push) begin
        blk_pend_q <= 1'b0;
      end else if (bus.block_start_i) begin
        blk_pend_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------
  logic load;
  logic pop;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= full_word;
    end
  end

  // Push and pop together leave the count unchanged, including when full.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The head stays in the FIFO while presented and is popped on ack, so
  // a word can never leave without an ack.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          load    = 1'b1;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (bus.ack_i) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      sent_q    <= '0;
      ack_cnt_q <= '0;
      ack_err_q <= 1'b0;
    end else begin
      if (load) begin
        data_q  <= fifo_mem[rd_ptr_q];
        valid_q <= 1'b1;
      end else if (pop) begin
        valid_q <= 1'b0;
      end

      if (pop) begin
        sent_q <= sent_q + 32'd1;
      end

      // Counts cycles spent presenting without an ack; saturates so the
      // flag cannot re-trigger through wrap-around.
      if ((state_q == S_PRESENT) && !pop) begin
        if (ack_cnt_q != ACK_MAX) begin
          ack_cnt_q <= ack_cnt_q + KW'(1);
        end
        if (ack_cnt_q == ACK_LAST) begin
          ack_err_q <= 1'b1;
        end
      end else begin
        ack_cnt_q <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.byte_ready_o = byte_ready;
  assign bus.data_o       = data_q;
  assign bus.valid_o      = valid_q;

  assign sent_count_o = sent_q;
  assign drop_count_o = drop_q;
  assign ack_err_o    = ack_err_q;
  assign busy_o       = (byte_idx_q != 4'd0) || (count_q != '0) || valid_q;
  assign state_dbg_o  = (state_q == S_PRESENT);

endmodule
